// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind the CPU data port, with access counters and fault capture.
// Optional post-reset zero fill is enabled by defining DMEM_INIT_CLEAR_EN.
module dmem_responder #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_out,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic [31:0]      data_in,
  output logic             busy,
  input  logic             fault_clr,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [31:0]      fault_addr,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int unsigned LIM = DEPTH * 4;

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_clr_idx;
  logic [AW-1:0]     w_clr_idx_nxt;
  logic [31:0]       r_mem [DEPTH];

  logic              r_fault;
  logic [1:0]        r_fault_code;
  logic [31:0]       r_fault_addr;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [CNT_W-1:0]  r_wr_cnt;

  logic              w_ready;
  logic              w_req;
  logic              w_both;
  logic              w_mis;
  logic              w_oor;
  logic              w_fault;
  logic [1:0]        w_code;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic              w_clr_we;
  logic [AW-1:0]     w_idx;

  assign w_idx   = data_addr[AW+1:2];
  assign w_ready = (r_state == S_READY);
  assign w_req   = mem_read | mem_write;
  assign w_both  = mem_read & mem_write;
  assign w_mis   = |data_addr[1:0];
  assign w_oor   = (data_addr >= 32'(LIM));
  assign w_fault = w_ready & w_req & (w_both | w_mis | w_oor);

  always_comb begin
    w_code = 2'b10;
    if (w_both)     w_code = 2'b11;
    else if (w_mis) w_code = 2'b01;
  end

  assign w_rd_ok = ~rst & w_ready & mem_read & ~mem_write & ~w_mis & ~w_oor;
  assign w_wr_ok = ~rst & w_ready & mem_write & ~mem_read & ~w_mis & ~w_oor;

  assign data_in = w_rd_ok ? r_mem[w_idx] : 32'h0;

`ifdef DMEM_INIT_CLEAR_EN
  localparam state_t RST_STATE = S_CLEAR;
  assign w_clr_we = ~rst & (r_state == S_CLEAR);
  assign busy     = (r_state == S_CLEAR);
`else
  localparam state_t RST_STATE = S_READY;
  assign w_clr_we = 1'b0;
  assign busy     = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      S_CLEAR: begin
        w_clr_idx_nxt = r_clr_idx + AW'(1);
        if (r_clr_idx == AW'(DEPTH - 1)) w_state_nxt = S_READY;
      end
      default: w_state_nxt = S_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RST_STATE;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr_we)     r_mem[r_clr_idx] <= 32'h0;
    else if (w_wr_ok) r_mem[w_idx]     <= data_out;
  end

  // A fault arriving with fault_clr wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault      <= 1'b0;
      r_fault_code <= 2'b00;
      r_fault_addr <= 32'h0;
    end else if (w_fault && (!r_fault || fault_clr)) begin
      r_fault      <= 1'b1;
      r_fault_code <= w_code;
      r_fault_addr <= data_addr;
    end else if (fault_clr) begin
      r_fault      <= 1'b0;
      r_fault_code <= 2'b00;
      r_fault_addr <= 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_rd_ok && (r_rd_cnt != '1)) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      if (w_wr_ok && (r_wr_cnt != '1)) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
    end
  end

  assign fault      = r_fault;
  assign fault_code = r_fault_code;
  assign fault_addr = r_fault_addr;
  assign rd_count   = r_rd_cnt;
  assign wr_count   = r_wr_cnt;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed and random requests against a word-array model.
// A second instance with 4-bit counters shares the stimulus to cover saturation.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_out = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        fault_clr = 1'b0;

  logic [31:0] data_in, fault_addr;
  logic        busy, fault;
  logic [1:0]  fault_code;
  logic [15:0] rd_count, wr_count;

  logic [31:0] s_data_in, s_fault_addr;
  logic        s_busy, s_fault;
  logic [1:0]  s_fault_code;
  logic [3:0]  s_rd_count, s_wr_count;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .data_addr(data_addr), .data_out(data_out),
    .mem_read(mem_read), .mem_write(mem_write), .data_in(data_in),
    .busy(busy), .fault_clr(fault_clr), .fault(fault),
    .fault_code(fault_code), .fault_addr(fault_addr),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  dmem_responder #(.DEPTH(64), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .data_addr(data_addr), .data_out(data_out),
    .mem_read(mem_read), .mem_write(mem_write), .data_in(s_data_in),
    .busy(s_busy), .fault_clr(fault_clr), .fault(s_fault),
    .fault_code(s_fault_code), .fault_addr(s_fault_addr),
    .rd_count(s_rd_count), .wr_count(s_wr_count)
  );

  int          vectors = 0;
  int          miscompares = 0;

  logic [31:0] m_mem [64];
  int          m_rem;
  int          m_rd, m_wr, m_rd_s, m_wr_s;
  logic        m_fault;
  logic [1:0]  m_code;
  logic [31:0] m_faddr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic post_chk();
    chk("busy", 32'(busy), 32'(m_rem != 0));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("fault_code", 32'(fault_code), 32'(m_code));
    chk("fault_addr", fault_addr, m_faddr);
    chk("rd_count", 32'(rd_count), 32'(m_rd));
    chk("wr_count", 32'(wr_count), 32'(m_wr));
    chk("rd_count_sat4", 32'(s_rd_count), 32'(m_rd_s));
    chk("wr_count_sat4", 32'(s_wr_count), 32'(m_wr_s));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; fault_clr = 1'b0;
    data_addr = '0; data_out = '0;
    @(posedge clk);
    m_rd = 0; m_wr = 0; m_rd_s = 0; m_wr_s = 0;
    m_fault = 1'b0; m_code = 2'b00; m_faddr = '0;
`ifdef DMEM_INIT_CLEAR_EN
    m_rem = 64;
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
`else
    m_rem = 0;
`endif
    #1;
    post_chk();
    chk("data_in_rst", data_in, 32'h0);
  endtask

  task automatic cyc(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic clr);
    logic [1:0]  code;
    logic        ready, req, valid;
    logic [31:0] exp_rd;
    int          idx;
    @(negedge clk);
    rst = 1'b0; mem_read = rd; mem_write = wr;
    data_addr = a; data_out = d; fault_clr = clr;
    ready = (m_rem == 0);
    req = rd | wr;
    code = 2'b00;
    if (ready && req) begin
      if (rd && wr)          code = 2'b11;
      else if (a[1:0] != 0)  code = 2'b01;
      else if (a >= 32'd256) code = 2'b10;
    end
    valid = ready && req && (code == 2'b00);
    idx = int'(a[7:2]);
    exp_rd = (valid && rd) ? m_mem[idx] : 32'h0;
    #1;
    chk("data_in", data_in, exp_rd);
    chk("data_in_sat4", s_data_in, exp_rd);
    @(posedge clk);
    if (code != 2'b00 && (!m_fault || clr)) begin
      m_fault = 1'b1; m_code = code; m_faddr = a;
    end else if (clr) begin
      m_fault = 1'b0; m_code = 2'b00; m_faddr = '0;
    end
    if (valid && rd) begin
      if (m_rd < 65535) m_rd++;
      if (m_rd_s < 15) m_rd_s++;
    end
    if (valid && wr) begin
      m_mem[idx] = d;
      if (m_wr < 65535) m_wr++;
      if (m_wr_s < 15) m_wr_s++;
    end
    if (!ready) m_rem--;
    #1;
    post_chk();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    int          k;
    logic        rd, wr;

    // Preload every word with a marker, then reset to exercise the fill.
    do_reset();
    idle(64);
    for (int i = 0; i < 64; i++) cyc(1'b0, 1'b1, 32'(i * 4), 32'hDEADBEEF, 1'b0);
    do_reset();
    idle(64);
    idle(1);
    cyc(1'b1, 1'b0, 32'h0FC, 32'h0, 1'b0);

    // Store/load back to back.
    do_reset();
    idle(64);
    cyc(1'b0, 1'b1, 32'h000, 32'd10, 1'b0);
    cyc(1'b0, 1'b1, 32'h004, 32'd20, 1'b0);
    cyc(1'b1, 1'b0, 32'h004, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h000, 32'h0, 1'b0);

    // Misaligned store, later out-of-range load keeps first code, then clear.
    cyc(1'b0, 1'b1, 32'h006, 32'h55, 1'b0);
    cyc(1'b1, 1'b0, 32'h004, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Collision, then clear coinciding with a new fault.
    cyc(1'b0, 1'b1, 32'h008, 32'h1234, 1'b0);
    cyc(1'b1, 1'b1, 32'h008, 32'd7, 1'b0);
    cyc(1'b1, 1'b0, 32'h008, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h200, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Saturation of the 4-bit counters.
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 9));
      if (k <= 6)      a = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      else if (k == 7) a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else if (k == 8) a = 32'h100 + 32'($urandom_range(0, 255));
      else             a = $urandom;
      k = int'($urandom_range(0, 7));
      rd = (k <= 2) || (k == 6);
      wr = (k >= 3 && k <= 5) || (k == 6);
      cyc(rd, wr, a, $urandom, ($urandom_range(0, 15) == 0));
    end

    // Reset part-way through the fill, store while busy.
    do_reset();
    idle(30);
    do_reset();
    cyc(1'b0, 1'b1, 32'h010, 32'hA5A5A5A5, 1'b0);
    idle(63);
    idle(1);
    cyc(1'b1, 1'b0, 32'h010, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
